// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM block reader.
package avmm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view (show-ahead) and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/avmm_block_reader.sv
// Reads a block of consecutive words over Avalon-MM and streams them out as one
// Avalon-ST packet, throttling reads so in-flight data always fits the FIFO.
module avmm_block_reader
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + 2;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  rx_q;
  logic [CNT_W-1:0]  outst_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              credit_ok;
  logic              accept;
  logic              last_accept;
  logic              take;
  logic              pop;
  logic              word_sop;
  logic              word_eop;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  head;

  // Credit: every outstanding read has a reserved FIFO slot.
  assign credit_ok   = (CRD_W'(outst_q) + CRD_W'(fifo_count)) < CRD_W'(FIFO_DEPTH);
  assign m_read      = (state == ISSUE) && (issued_q != len_q) && credit_ok;
  assign accept      = m_read && !m_waitrequest;
  assign last_accept = accept && ((issued_q + LEN_W'(1)) == len_q);
  // Beats arriving outside a live command (e.g. after a reset) are dropped.
  assign take        = m_readdatavalid && ((state == ISSUE) || (state == DRAIN))
                       && (outst_q != '0);

  assign m_address    = addr_q;
  assign m_byteenable = BYTEEN_ALL;
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

  assign word_sop  = (rx_q == '0);
  assign word_eop  = (rx_q == (len_q - LEN_W'(1)));
  assign push_data = {word_sop, word_eop, m_readdata};

  assign st_valid = !fifo_empty;
  assign st_data  = head[DATA_W-1:0];
  assign st_sop   = head[DATA_W+1] && st_valid;
  assign st_eop   = head[DATA_W] && st_valid;
  assign pop      = st_valid && st_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (last_accept) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && fifo_empty) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command registers, address walker and read/response counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      rx_q     <= '0;
      outst_q  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        addr_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
        rx_q     <= '0;
      end
      if (accept) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + LEN_W'(1);
      end
      if (take) begin
        rx_q <= rx_q + LEN_W'(1);
      end
      case ({accept, take})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (take),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
